// File: rtl/match_controller_if.sv
// rtl/match_controller_if.sv - Signal bundle between the match controller and the ball engine / inputs.
interface match_controller_if;
  logic       start;
  logic       pause;
  logic       frame_tick;
  logic       miss_a;
  logic       miss_b;
  logic       ball_enable;
  logic       serve;
  logic       serve_dir;
  logic [3:0] score_a;
  logic [3:0] score_b;
  logic [2:0] state;
  logic       winner;

  modport master (
    input  start, pause, frame_tick, miss_a, miss_b,
    output ball_enable, serve, serve_dir, score_a, score_b, state, winner
  );

  modport slave (
    output start, pause, frame_tick, miss_a, miss_b,
    input  ball_enable, serve, serve_dir, score_a, score_b, state, winner
  );
endinterface

// File: rtl/match_controller.sv
// rtl/match_controller.sv - Pong match FSM: serve timing, scoring, game over.
// Optional pause support is compiled in when PAUSE_EN is defined.
module match_controller #(
  parameter int WIN_SCORE    = 11,
  parameter int SERVE_FRAMES = 120
) (
  input  logic               i_vga_clock,
  input  logic               i_reset,
  match_controller_if.master io_bus
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SERVE_WAIT = 3'd1,
    ST_PLAY       = 3'd2,
    ST_POINT      = 3'd3,
    ST_GAME_OVER  = 3'd4
  } state_t;

  localparam logic [3:0] LP_WIN  = 4'(WIN_SCORE);
  localparam logic [7:0] LP_LAST = 8'(SERVE_FRAMES - 1);

  state_t     r_state;
  logic [3:0] r_score_a;
  logic [3:0] r_score_b;
  logic [7:0] r_frame_cnt;
  logic       r_serve;
  logic       r_serve_dir;
  logic       r_winner;
  logic       r_start_d;

  state_t     w_state_nxt;
  logic [3:0] w_score_a_nxt;
  logic [3:0] w_score_b_nxt;
  logic [7:0] w_frame_cnt_nxt;
  logic       w_serve_nxt;
  logic       w_serve_dir_nxt;
  logic       w_winner_nxt;
  logic       w_start_rise;
  logic       w_paused;

  assign w_start_rise = io_bus.start & ~r_start_d;

`ifdef PAUSE_EN
  logic r_pause_d;
  logic r_paused;
  logic w_paused_nxt;

  always_comb begin
    w_paused_nxt = r_paused;
    if (r_state == ST_PLAY && io_bus.pause && !r_pause_d) begin
      w_paused_nxt = ~r_paused;
    end
    // The flag only has meaning inside a rally; drop it whenever PLAY is left.
    if (w_state_nxt != ST_PLAY) begin
      w_paused_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_vga_clock) begin
    if (i_reset) begin
      r_pause_d <= io_bus.pause;
      r_paused  <= 1'b0;
    end else begin
      r_pause_d <= io_bus.pause;
      r_paused  <= w_paused_nxt;
    end
  end

  assign w_paused = r_paused;
`else
  logic w_pause_unused;
  assign w_pause_unused = io_bus.pause;
  assign w_paused       = 1'b0;
`endif

  always_ff @(posedge i_vga_clock) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_score_a   <= 4'd0;
      r_score_b   <= 4'd0;
      r_frame_cnt <= 8'd0;
      r_serve     <= 1'b0;
      r_serve_dir <= 1'b1;
      r_winner    <= 1'b0;
      r_start_d   <= io_bus.start;
    end else begin
      r_state     <= w_state_nxt;
      r_score_a   <= w_score_a_nxt;
      r_score_b   <= w_score_b_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_serve     <= w_serve_nxt;
      r_serve_dir <= w_serve_dir_nxt;
      r_winner    <= w_winner_nxt;
      r_start_d   <= io_bus.start;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_score_a_nxt   = r_score_a;
    w_score_b_nxt   = r_score_b;
    w_frame_cnt_nxt = r_frame_cnt;
    w_serve_nxt     = 1'b0;
    w_serve_dir_nxt = r_serve_dir;
    w_winner_nxt    = r_winner;

    case (r_state)
      ST_IDLE, ST_GAME_OVER: begin
        if (w_start_rise) begin
          w_state_nxt     = ST_SERVE_WAIT;
          w_score_a_nxt   = 4'd0;
          w_score_b_nxt   = 4'd0;
          w_serve_dir_nxt = 1'b1;
          w_frame_cnt_nxt = 8'd0;
        end
      end

      ST_SERVE_WAIT: begin
        if (io_bus.frame_tick) begin
          if (r_frame_cnt == LP_LAST) begin
            w_state_nxt = ST_PLAY;
            w_serve_nxt = 1'b1;
          end else begin
            w_frame_cnt_nxt = r_frame_cnt + 8'd1;
          end
        end
      end

      ST_PLAY: begin
        if (!w_paused) begin
          // A double miss is a let: replay without awarding anyone.
          if (io_bus.miss_a && io_bus.miss_b) begin
            w_state_nxt = ST_POINT;
          end else if (io_bus.miss_a) begin
            w_state_nxt     = ST_POINT;
            w_serve_dir_nxt = 1'b0;
            if (r_score_b < LP_WIN) begin
              w_score_b_nxt = r_score_b + 4'd1;
            end
          end else if (io_bus.miss_b) begin
            w_state_nxt     = ST_POINT;
            w_serve_dir_nxt = 1'b1;
            if (r_score_a < LP_WIN) begin
              w_score_a_nxt = r_score_a + 4'd1;
            end
          end
        end
      end

      ST_POINT: begin
        if (r_score_a == LP_WIN) begin
          w_state_nxt  = ST_GAME_OVER;
          w_winner_nxt = 1'b0;
        end else if (r_score_b == LP_WIN) begin
          w_state_nxt  = ST_GAME_OVER;
          w_winner_nxt = 1'b1;
        end else begin
          w_state_nxt     = ST_SERVE_WAIT;
          w_frame_cnt_nxt = 8'd0;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign io_bus.ball_enable = (r_state == ST_PLAY) && !w_paused;
  assign io_bus.serve       = r_serve;
  assign io_bus.serve_dir   = r_serve_dir;
  assign io_bus.score_a     = r_score_a;
  assign io_bus.score_b     = r_score_b;
  assign io_bus.state       = r_state;
  assign io_bus.winner      = r_winner;

endmodule

// File: tb/tb_match_controller.sv
// tb/tb_match_controller.sv - Self-checking bench for match_controller (WIN_SCORE=3, SERVE_FRAMES=2).
module tb_match_controller;
  localparam int WIN    = 3;
  localparam int FRAMES = 2;

  typedef struct packed {
    logic       dir;
    logic [3:0] a;
    logic [3:0] b;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;
  exp_t sb_q[$];

  match_controller_if bus();

  match_controller #(
    .WIN_SCORE   (WIN),
    .SERVE_FRAMES(FRAMES)
  ) dut (
    .i_vga_clock(clk),
    .i_reset    (rst),
    .io_bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic miss(input logic a, input logic b);
    bus.miss_a = a;
    bus.miss_b = b;
    step();
    bus.miss_a = 1'b0;
    bus.miss_b = 1'b0;
  endtask

  // Feed frame ticks on alternate cycles until PLAY, expecting one serve.
  task automatic run_serve(input logic [3:0] ea, input logic [3:0] eb, input logic edir);
    int n;
    int ticks;
    exp_t e;
    e.dir = edir;
    e.a   = ea;
    e.b   = eb;
    sb_q.push_back(e);
    n     = 0;
    ticks = 0;
    while (bus.state != 3'd2 && n < 40) begin
      bus.frame_tick = (n % 2 == 0);
      if (n % 2 == 0) ticks++;
      step();
      bus.frame_tick = 1'b0;
      if (bus.state != 3'd2) check("sw_ball_off", bus.ball_enable, 0);
      n++;
    end
    check("serve_reach_play", bus.state, 2);
    check("serve_frames", ticks, FRAMES);
    check("serve_high", bus.serve, 1);
    check("play_ball_en", bus.ball_enable, 1);
    step();
    check("serve_one_cycle", bus.serve, 0);
  endtask

  always @(negedge clk) begin
    if (bus.serve === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_serve", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_serve_dir", bus.serve_dir, e.dir);
        check("sb_score_a", bus.score_a, e.a);
        check("sb_score_b", bus.score_b, e.b);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_checks       = 0;
    n_err          = 0;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.pause      = 1'b0;
    bus.frame_tick = 1'b0;
    bus.miss_a     = 1'b0;
    bus.miss_b     = 1'b0;
    step();
    step();
    check("rst_state", bus.state, 0);
    check("rst_score_a", bus.score_a, 0);
    check("rst_score_b", bus.score_b, 0);
    check("rst_ball_en", bus.ball_enable, 0);
    check("rst_serve", bus.serve, 0);
    check("rst_serve_dir", bus.serve_dir, 1);
    check("rst_winner", bus.winner, 0);
    rst = 1'b0;
    step();
    check("idle_hold", bus.state, 0);

    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("start_to_sw", bus.state, 1);
    run_serve(4'd0, 4'd0, 1'b1);

    // START edge during a rally is ignored
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("start_ignored_play", bus.state, 2);

    miss(1'b1, 1'b0);
    check("missa_point", bus.state, 3);
    check("missa_score_b", bus.score_b, 1);
    check("missa_dir", bus.serve_dir, 0);
    check("point_ball_off", bus.ball_enable, 0);
    step();
    check("missa_to_sw", bus.state, 1);
    miss(1'b0, 1'b1);
    check("miss_in_sw_ignored", bus.score_a, 0);
    run_serve(4'd0, 4'd1, 1'b0);

    miss(1'b1, 1'b1);
    check("dbl_point", bus.state, 3);
    check("dbl_score_a", bus.score_a, 0);
    check("dbl_score_b", bus.score_b, 1);
    check("dbl_dir", bus.serve_dir, 0);
    step();
    check("dbl_to_sw", bus.state, 1);
    run_serve(4'd0, 4'd1, 1'b0);

    for (int i = 1; i <= WIN; i++) begin
      miss(1'b0, 1'b1);
      check("missb_point", bus.state, 3);
      check("missb_score_a", bus.score_a, i);
      check("missb_dir", bus.serve_dir, 1);
      step();
      if (i < WIN) begin
        check("missb_to_sw", bus.state, 1);
        run_serve(i[3:0], 4'd1, 1'b1);
      end
    end
    check("go_state", bus.state, 4);
    check("go_winner", bus.winner, 0);
    check("go_ball_off", bus.ball_enable, 0);
    miss(1'b0, 1'b1);
    miss(1'b1, 1'b0);
    check("go_sat_a", bus.score_a, WIN);
    check("go_hold_b", bus.score_b, 1);
    check("go_hold_state", bus.state, 4);

    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("restart_sw", bus.state, 1);
    check("restart_a", bus.score_a, 0);
    check("restart_b", bus.score_b, 0);
    check("restart_dir", bus.serve_dir, 1);
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    check("cnt1_still_sw", bus.state, 1);

    rst       = 1'b1;
    bus.start = 1'b1;
    step();
    check("midrst_state", bus.state, 0);
    check("midrst_scores", {bus.score_a, bus.score_b}, 0);
    check("midrst_serve", bus.serve, 0);
    rst = 1'b0;
    repeat (3) step();
    check("start_held_no_edge", bus.state, 0);
    bus.start = 1'b0;
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("start_after_rst", bus.state, 1);
    run_serve(4'd0, 4'd0, 1'b1);

`ifdef PAUSE_EN
    bus.pause = 1'b1;
    step();
    bus.pause = 1'b0;
    check("pause_ball_off", bus.ball_enable, 0);
    miss(1'b1, 1'b0);
    check("pause_miss_ignored", bus.score_b, 0);
    check("pause_state", bus.state, 2);
    bus.pause = 1'b1;
    step();
    bus.pause = 1'b0;
    check("unpause_ball_on", bus.ball_enable, 1);
`else
    bus.pause = 1'b1;
    step();
    bus.pause = 1'b0;
    check("pause_ignored", bus.ball_enable, 1);
    check("pause_ignored_state", bus.state, 2);
`endif

    step();
    check("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/match_controller.md
MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 11, range 1..15: points needed to win a match.
REQ-002 SHALL have parameter SERVE_FRAMES, default 120, range 1..255: FRAME_TICK pulses waited before each serve.
REQ-003 VGA_CLOCK  in  1  sole clock; all logic on its rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 START  in  1  level, synchronous to VGA_CLOCK; rising edge detected internally.
REQ-006 PAUSE  in  1  level, synchronous; rising edge detected internally; used only under PAUSE_EN.
REQ-007 FRAME_TICK  in  1  one-cycle pulse per video frame.
REQ-008 MISS_A / MISS_B  in  1 each  one-cycle pulse: ball passed paddle A (left) or paddle B (right).
REQ-009 BALL_ENABLE  out  1  high = ball engine may move and draw the ball.
REQ-010 SERVE  out  1  one-cycle pulse: engine recentres the ball and launches it.
REQ-011 SERVE_DIR  out  1  1 = launch toward B (right), 0 = toward A; stable whenever SERVE is high.
REQ-012 SCORE_A / SCORE_B  out  4 each  current points.
REQ-013 STATE  out  3  encoded state: IDLE=0, SERVE_WAIT=1, PLAY=2, POINT=3, GAME_OVER=4.
REQ-014 WINNER  out  1  0 = A, 1 = B; valid only in GAME_OVER.

Function
REQ-015 IDLE: BALL_ENABLE=0; START rising edge -> SERVE_WAIT with SERVE_DIR=1 and both scores cleared.
REQ-016 SERVE_WAIT: 8-bit frame counter is cleared on entry and increments per FRAME_TICK; BALL_ENABLE=0.
REQ-017 On the cycle FRAME_TICK is sampled with counter==SERVE_FRAMES-1: next cycle SERVE=1 for exactly one cycle, STATE=PLAY, BALL_ENABLE=1.
REQ-018 PLAY, MISS_A alone -> SCORE_B+1, SERVE_DIR=0, go POINT; MISS_B alone -> SCORE_A+1, SERVE_DIR=1, go POINT.
REQ-019 PLAY, MISS_A and MISS_B in the same cycle -> no score change, SERVE_DIR unchanged, go POINT.
REQ-020 POINT lasts one cycle with BALL_ENABLE=0; if either score equals WIN_SCORE -> GAME_OVER with WINNER set to that side, else -> SERVE_WAIT.
REQ-021 GAME_OVER: BALL_ENABLE=0, scores held; START rising edge -> clear scores, SERVE_DIR=1, go SERVE_WAIT.
REQ-022 MISS_A/MISS_B outside PLAY are ignored; START edges outside IDLE/GAME_OVER are ignored.
REQ-023 Scores never exceed WIN_SCORE and never wrap.
REQ-024 A START level held high across reset release SHALL NOT count as a rising edge.

Reset
REQ-025 RESET high at any clock edge, including mid-match: STATE=IDLE, scores=0, BALL_ENABLE=0, SERVE=0, SERVE_DIR=1, WINNER=0, frame counter=0, pause flag=0, START/PAUSE edge registers loaded with current input levels.

Configuration
REQ-026 Macro PAUSE_EN defined: PAUSE rising edge in PLAY toggles a pause flag; while paused BALL_ENABLE=0 and MISS pulses are ignored; flag clears on leaving PLAY.
REQ-027 PAUSE_EN undefined: PAUSE port present but ignored; no pause flag logic.

Verification
REQ-028 Reset, START edge, WIN_SCORE=3, SERVE_FRAMES=2: SERVE pulses one cycle after the 2nd FRAME_TICK, STATE=2, BALL_ENABLE=1, SERVE_DIR=1.
REQ-029 In PLAY pulse MISS_A: SCORE_B=1, STATE 2->3->1, SERVE_DIR=0, BALL_ENABLE=0 until next SERVE.
REQ-030 MISS_B three times (re-serving each time): after third, STATE=4, WINNER=0, SCORE_A=3; further MISS pulses leave scores at 3.
REQ-031 MISS_A and MISS_B same cycle in PLAY: scores unchanged, STATE goes 3 then 1, SERVE_DIR unchanged.
REQ-032 RESET asserted in SERVE_WAIT with counter=1: next cycle STATE=0, scores=0; START held high through reset produces no SERVE_WAIT entry.
REQ-033 With PAUSE_EN, PAUSE edge in PLAY: BALL_ENABLE=0, MISS_A ignored (SCORE_B unchanged); second PAUSE edge restores BALL_ENABLE=1.
